// File: rtl/riscv_exec_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_exec_pkg : opcodes, ALU op codes, ImmSel/WBSel encodings   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package riscv_exec_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_sel_e;

  typedef enum logic [1:0] {
    WB_MEM = 2'd0,
    WB_ALU = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_e;

  // alt selects SUB/SRA; callers decide when funct7[5] is meaningful
  function automatic alu_op_e alu_op_from_funct(input logic [2:0] funct3, input logic alt);
    alu_op_e op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_exec_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_exec_ctrl_if : operand inputs and decode/ALU/status outputs|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface riscv_exec_ctrl_if;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic [2:0]  ImmSel;
  logic        ASel;
  logic        BSel;
  logic        BrUn;
  logic        MemRW;
  logic        RegWEn;
  logic [1:0]  WBSel;
  logic        PCSel;
  logic [3:0]  ALUControl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_sign;
  logic        branch_taken;
  logic        illegal;
  logic        illegal_sticky;
  logic [31:0] store_count;
  logic [31:0] last_store_addr;
  logic [31:0] last_store_data;

  modport master (
    output instr, pc, rs1_data, rs2_data, imm,
    input  ImmSel, ASel, BSel, BrUn, MemRW, RegWEn, WBSel, PCSel, ALUControl,
    input  alu_result, alu_zero, alu_sign, branch_taken, illegal, illegal_sticky,
    input  store_count, last_store_addr, last_store_data
  );

  modport slave (
    input  instr, pc, rs1_data, rs2_data, imm,
    output ImmSel, ASel, BSel, BrUn, MemRW, RegWEn, WBSel, PCSel, ALUControl,
    output alu_result, alu_zero, alu_sign, branch_taken, illegal, illegal_sticky,
    output store_count, last_store_addr, last_store_data
  );
endinterface
`default_nettype wire

// File: rtl/riscv_exec_ctrl_alu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_alu : 32-bit RV32I ALU, unused op codes yield zero         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module riscv_alu
  import riscv_exec_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  alu_control_i,
  output logic [31:0] result_o,
  output logic        zero_o,
  output logic        sign_o
);

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = '0;
    case (alu_control_i)
      ALU_ADD:    result_o = a_i + b_i;
      ALU_SUB:    result_o = a_i - b_i;
      ALU_SLL:    result_o = a_i << shamt;
      ALU_SLT:    result_o = {31'b0, $signed(a_i) < $signed(b_i)};
      ALU_SLTU:   result_o = {31'b0, a_i < b_i};
      ALU_XOR:    result_o = a_i ^ b_i;
      ALU_SRL:    result_o = a_i >> shamt;
      ALU_SRA:    result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OR:     result_o = a_i | b_i;
      ALU_AND:    result_o = a_i & b_i;
      ALU_PASS_B: result_o = b_i;
      default:    result_o = '0;
    endcase
  end

  assign zero_o = (result_o == 32'd0);
  assign sign_o = result_o[31];

endmodule
`default_nettype wire

// File: rtl/riscv_exec_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_exec_ctrl : RV32I decode, ALU, branch compare, status regs |
// | Optional macro STORE_TRACE_EN adds store count/address/data regs |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module riscv_exec_ctrl
  import riscv_exec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  riscv_exec_ctrl_if.slave  bus
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  imm_sel_e    imm_sel;
  wb_sel_e     wb_sel;
  alu_op_e     alu_op;
  logic        a_sel, b_sel, mem_rw, reg_wen, pc_sel;
  logic        is_branch, is_jump, illegal;
  logic        br_un, br_eq, br_lt, br_cond;
  logic [31:0] op_a, op_b, alu_result;
  logic        illegal_sticky_q, illegal_sticky_d;
  logic        unused_instr_bits;

  assign opcode   = bus.instr[6:0];
  assign funct3   = bus.instr[14:12];
  assign funct7_5 = bus.instr[30];
  assign unused_instr_bits = ^{bus.instr[31], bus.instr[29:15], bus.instr[11:7]};

  always_comb begin
    imm_sel   = IMM_I;
    wb_sel    = WB_MEM;
    alu_op    = ALU_ADD;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    mem_rw    = 1'b0;
    reg_wen   = 1'b0;
    pc_sel    = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPC_OP: begin
        alu_op  = alu_op_from_funct(funct3, funct7_5);
        reg_wen = 1'b1;
        wb_sel  = WB_ALU;
      end
      OPC_OP_IMM: begin
        // only SRAI borrows funct7[5]; other I-type immediates may set bit 30
        alu_op  = alu_op_from_funct(funct3, funct7_5 && (funct3 == 3'b101));
        b_sel   = 1'b1;
        reg_wen = 1'b1;
        wb_sel  = WB_ALU;
      end
      OPC_LOAD: begin
        b_sel   = 1'b1;
        reg_wen = 1'b1;
      end
      OPC_STORE: begin
        imm_sel = IMM_S;
        b_sel   = 1'b1;
        mem_rw  = 1'b1;
      end
      OPC_BRANCH: begin
        imm_sel   = IMM_B;
        a_sel     = 1'b1;
        b_sel     = 1'b1;
        is_branch = 1'b1;
        illegal   = (funct3[2:1] == 2'b01);
        pc_sel    = (funct3[2:1] != 2'b01);
      end
      OPC_JAL: begin
        imm_sel = IMM_J;
        a_sel   = 1'b1;
        b_sel   = 1'b1;
        pc_sel  = 1'b1;
        reg_wen = 1'b1;
        wb_sel  = WB_PC4;
        is_jump = 1'b1;
      end
      OPC_JALR: begin
        b_sel   = 1'b1;
        pc_sel  = 1'b1;
        reg_wen = 1'b1;
        wb_sel  = WB_PC4;
        is_jump = 1'b1;
      end
      OPC_LUI: begin
        imm_sel = IMM_U;
        b_sel   = 1'b1;
        alu_op  = ALU_PASS_B;
        reg_wen = 1'b1;
        wb_sel  = WB_ALU;
      end
      OPC_AUIPC: begin
        imm_sel = IMM_U;
        a_sel   = 1'b1;
        b_sel   = 1'b1;
        reg_wen = 1'b1;
        wb_sel  = WB_ALU;
      end
      default: illegal = 1'b1;
    endcase
  end

  assign br_un = is_branch & funct3[1];
  assign br_eq = (bus.rs1_data == bus.rs2_data);
  assign br_lt = br_un ? (bus.rs1_data < bus.rs2_data)
                       : ($signed(bus.rs1_data) < $signed(bus.rs2_data));

  always_comb begin
    case (funct3)
      3'b000:  br_cond = br_eq;
      3'b001:  br_cond = ~br_eq;
      3'b100:  br_cond = br_lt;
      3'b101:  br_cond = ~br_lt;
      3'b110:  br_cond = br_lt;
      3'b111:  br_cond = ~br_lt;
      default: br_cond = 1'b0;
    endcase
  end

  assign op_a = a_sel ? bus.pc  : bus.rs1_data;
  assign op_b = b_sel ? bus.imm : bus.rs2_data;

  riscv_alu u_alu (
    .a_i           (op_a),
    .b_i           (op_b),
    .alu_control_i (alu_op),
    .result_o      (alu_result),
    .zero_o        (bus.alu_zero),
    .sign_o        (bus.alu_sign)
  );

  assign bus.ImmSel       = imm_sel;
  assign bus.WBSel        = wb_sel;
  assign bus.ALUControl   = alu_op;
  assign bus.ASel         = a_sel;
  assign bus.BSel         = b_sel;
  assign bus.BrUn         = br_un;
  assign bus.MemRW        = mem_rw;
  assign bus.RegWEn       = reg_wen;
  assign bus.PCSel        = pc_sel;
  assign bus.alu_result   = alu_result;
  assign bus.illegal      = illegal;
  assign bus.branch_taken = (is_branch & ~illegal & br_cond) | is_jump;

  assign illegal_sticky_d = illegal_sticky_q | illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) illegal_sticky_q <= 1'b0;
    else     illegal_sticky_q <= illegal_sticky_d;
  end

  assign bus.illegal_sticky = illegal_sticky_q;

`ifdef STORE_TRACE_EN
  logic [31:0] store_count_q, store_count_d;
  logic [31:0] last_store_addr_q, last_store_addr_d;
  logic [31:0] last_store_data_q, last_store_data_d;

  assign store_count_d     = mem_rw ? store_count_q + 32'd1 : store_count_q;
  assign last_store_addr_d = mem_rw ? alu_result            : last_store_addr_q;
  assign last_store_data_d = mem_rw ? bus.rs2_data          : last_store_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_count_q     <= '0;
      last_store_addr_q <= '0;
      last_store_data_q <= '0;
    end else begin
      store_count_q     <= store_count_d;
      last_store_addr_q <= last_store_addr_d;
      last_store_data_q <= last_store_data_d;
    end
  end

  assign bus.store_count     = store_count_q;
  assign bus.last_store_addr = last_store_addr_q;
  assign bus.last_store_data = last_store_data_q;
`else
  assign bus.store_count     = '0;
  assign bus.last_store_addr = '0;
  assign bus.last_store_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_exec_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_riscv_exec_ctrl : directed vectors for riscv_exec_ctrl        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_riscv_exec_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] exp_cnt, exp_addr, exp_data;

  logic [31:0] alu_a, alu_b, alu_res;
  logic [3:0]  alu_ctl;
  logic        alu_z, alu_s;

  always #5 clk = ~clk;

  riscv_exec_ctrl_if bus ();

  riscv_exec_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  riscv_alu u_alu_chk (
    .a_i           (alu_a),
    .b_i           (alu_b),
    .alu_control_i (alu_ctl),
    .result_o      (alu_res),
    .zero_o        (alu_z),
    .sign_o        (alu_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] p);
    @(negedge clk);
    bus.instr    = i;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
    bus.imm      = im;
    bus.pc       = p;
    #1;
  endtask

  initial begin
    bus.instr    = 32'h0000_0013;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.imm      = '0;
    bus.pc       = '0;
    alu_a = 32'd5; alu_b = 32'd7; alu_ctl = 4'd11;
`ifdef STORE_TRACE_EN
    exp_cnt = 32'd1; exp_addr = 32'h100; exp_data = 32'hAB;
`else
    exp_cnt = 32'd0; exp_addr = 32'd0;   exp_data = 32'd0;
`endif

    repeat (2) @(negedge clk);
    chk("rst_sticky", 32'(bus.illegal_sticky), 0);
    chk("rst_cnt",    bus.store_count, 0);
    chk("rst_addr",   bus.last_store_addr, 0);
    chk("rst_data",   bus.last_store_data, 0);
    rst = 1'b0;

    // ALU codes outside the defined set return zero
    #1;
    chk("alu_op11", alu_res, 0);
    chk("alu_op11_z", 32'(alu_z), 1);
    alu_ctl = 4'd15; #1;
    chk("alu_op15", alu_res, 0);
    alu_ctl = 4'd10; #1;
    chk("alu_passb", alu_res, 7);

    drive(32'h0020_81B3, 32'd5, 32'd7, 32'd0, 32'd0);
    chk("add_ctl", 32'(bus.ALUControl), 0);
    chk("add_res", bus.alu_result, 12);
    chk("add_wen", 32'(bus.RegWEn), 1);
    chk("add_wb",  32'(bus.WBSel), 1);
    chk("add_bsel", 32'(bus.BSel), 0);
    chk("add_ill", 32'(bus.illegal), 0);

    drive(32'h4020_81B3, 32'd9, 32'd9, 32'd0, 32'd0);
    chk("sub_ctl",  32'(bus.ALUControl), 1);
    chk("sub_res",  bus.alu_result, 0);
    chk("sub_zero", 32'(bus.alu_zero), 1);

    drive(32'h4040_D093, 32'h8000_0000, 32'd0, 32'h404, 32'd0);
    chk("srai_ctl",  32'(bus.ALUControl), 7);
    chk("srai_res",  bus.alu_result, 32'hF800_0000);
    chk("srai_sign", 32'(bus.alu_sign), 1);
    chk("srai_bsel", 32'(bus.BSel), 1);

    drive(32'h4000_8093, 32'd10, 32'd0, 32'h400, 32'd0);
    chk("addi_ctl", 32'(bus.ALUControl), 0);
    chk("addi_res", bus.alu_result, 32'h40A);

    drive(32'h0020_A1B3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    chk("slt_res", bus.alu_result, 1);
    drive(32'h0020_B1B3, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    chk("sltu_res", bus.alu_result, 0);
    drive(32'h0020_D1B3, 32'h8000_0000, 32'd4, 32'd0, 32'd0);
    chk("srl_res", bus.alu_result, 32'h0800_0000);
    drive(32'h0020_91B3, 32'h0000_0003, 32'd4, 32'd0, 32'd0);
    chk("sll_res", bus.alu_result, 32'h30);
    drive(32'h0020_C1B3, 32'h0000_00F0, 32'h3C, 32'd0, 32'd0);
    chk("xor_res", bus.alu_result, 32'hCC);
    drive(32'h0020_E1B3, 32'h0000_00F0, 32'h3C, 32'd0, 32'd0);
    chk("or_res", bus.alu_result, 32'hFC);
    drive(32'h0020_F1B3, 32'h0000_00F0, 32'h3C, 32'd0, 32'd0);
    chk("and_res", bus.alu_result, 32'h30);

    drive(32'h0020_C063, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    chk("blt_taken", 32'(bus.branch_taken), 1);
    chk("blt_brun",  32'(bus.BrUn), 0);
    chk("blt_pcsel", 32'(bus.PCSel), 1);
    chk("blt_wen",   32'(bus.RegWEn), 0);
    chk("blt_imm",   32'(bus.ImmSel), 2);
    chk("blt_asel",  32'(bus.ASel), 1);

    drive(32'h0020_E063, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    chk("bltu_taken", 32'(bus.branch_taken), 0);
    chk("bltu_brun",  32'(bus.BrUn), 1);
    chk("bltu_pcsel", 32'(bus.PCSel), 1);
    chk("bltu_wen",   32'(bus.RegWEn), 0);

    drive(32'h0020_D063, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    chk("bge_taken", 32'(bus.branch_taken), 0);
    drive(32'h0020_F063, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
    chk("bgeu_taken", 32'(bus.branch_taken), 1);
    drive(32'h0020_8063, 32'd3, 32'd3, 32'd0, 32'd0);
    chk("beq_taken", 32'(bus.branch_taken), 1);
    drive(32'h0020_9063, 32'd3, 32'd3, 32'd0, 32'd0);
    chk("bne_taken", 32'(bus.branch_taken), 0);

    drive(32'h0000_006F, 32'd0, 32'd0, 32'd8, 32'h100);
    chk("jal_imm",   32'(bus.ImmSel), 4);
    chk("jal_taken", 32'(bus.branch_taken), 1);
    chk("jal_wb",    32'(bus.WBSel), 2);
    chk("jal_res",   bus.alu_result, 32'h108);

    drive(32'h0000_8067, 32'h200, 32'd0, 32'd4, 32'h100);
    chk("jalr_asel",  32'(bus.ASel), 0);
    chk("jalr_taken", 32'(bus.branch_taken), 1);
    chk("jalr_res",   bus.alu_result, 32'h204);

    drive(32'h1234_50B7, 32'hDEAD_BEEF, 32'd0, 32'h1234_5000, 32'h40);
    chk("lui_ctl", 32'(bus.ALUControl), 10);
    chk("lui_res", bus.alu_result, 32'h1234_5000);
    chk("lui_imm", 32'(bus.ImmSel), 3);

    drive(32'h0000_0097, 32'd0, 32'd0, 32'h2000, 32'h1000);
    chk("auipc_res",  bus.alu_result, 32'h3000);
    chk("auipc_asel", 32'(bus.ASel), 1);

    drive(32'h0000_A083, 32'h10, 32'd0, 32'h4, 32'd0);
    chk("lw_wb",  32'(bus.WBSel), 0);
    chk("lw_wen", 32'(bus.RegWEn), 1);
    chk("lw_res", bus.alu_result, 32'h14);

    drive(32'h0020_A023, 32'hF0, 32'hAB, 32'h10, 32'd0);
    chk("sw_memrw", 32'(bus.MemRW), 1);
    chk("sw_wen",   32'(bus.RegWEn), 0);
    chk("sw_imm",   32'(bus.ImmSel), 1);
    chk("sw_res",   bus.alu_result, 32'h100);
    @(posedge clk); #1;
    chk("trace_cnt",  bus.store_count, exp_cnt);
    chk("trace_addr", bus.last_store_addr, exp_addr);
    chk("trace_data", bus.last_store_data, exp_data);
    chk("sticky_clean", 32'(bus.illegal_sticky), 0);

    drive(32'h0000_007F, 32'd1, 32'd2, 32'd3, 32'd0);
    chk("ill_flag",  32'(bus.illegal), 1);
    chk("ill_wen",   32'(bus.RegWEn), 0);
    chk("ill_memrw", 32'(bus.MemRW), 0);
    chk("ill_pcsel", 32'(bus.PCSel), 0);
    chk("ill_sticky_pre", 32'(bus.illegal_sticky), 0);
    @(posedge clk); #1;
    chk("ill_sticky_set", 32'(bus.illegal_sticky), 1);

    drive(32'h0020_81B3, 32'd5, 32'd7, 32'd0, 32'd0);
    @(posedge clk); #1;
    chk("ill_sticky_hold", 32'(bus.illegal_sticky), 1);
    #1 rst = 1'b1;
    #1;
    chk("arst_sticky", 32'(bus.illegal_sticky), 0);
    chk("arst_cnt",    bus.store_count, 0);
    chk("arst_comb",   bus.alu_result, 12);
    #1 rst = 1'b0;

    drive(32'h0020_A063, 32'd3, 32'd3, 32'd0, 32'd0);
    chk("brill_flag",  32'(bus.illegal), 1);
    chk("brill_pcsel", 32'(bus.PCSel), 0);
    chk("brill_taken", 32'(bus.branch_taken), 0);
    chk("brill_wen",   32'(bus.RegWEn), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
